// File: rtl/sb_cfg_switch_box_pkg.sv
// Shared constants and helpers for the configurable switch box.
package sb_cfg_switch_box_pkg;

    localparam int unsigned SEL_OFF  = 0;
    localparam int unsigned SEL_REL1 = 1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 32) && ((64'd1 << r) < 64'(v))) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned sel_w(input int unsigned nsides);
        return clog2(nsides);
    endfunction

    function automatic int unsigned cfg_bits(input int unsigned nsides, input int unsigned width);
        return nsides * width * clog2(nsides);
    endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Serial config shift chain with shadow/active registers and validated commit.
module sb_cfg_chain
    import sb_cfg_switch_box_pkg::*;
#(
    parameter int unsigned CFG_BITS   = 32,
    parameter int unsigned STRICT_LEN = 1
) (
    input  logic                prog_clk,
    input  logic                prog_rst_n,
    input  logic                prog_in,
    input  logic                prog_en,
    output logic                prog_out,
    output logic [CFG_BITS-1:0] active,
    output logic                cfg_valid,
    output logic                cfg_err
);

    localparam int unsigned CNT_W = clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] shadow;
    logic [CNT_W-1:0]    cnt;
    logic                prog_en_q;
    logic                commit_c;
    logic                len_ok_c;

    // Falling edge of prog_en requests a commit; length check decides acceptance.
    always_comb begin
        commit_c = prog_en_q & ~prog_en;
        len_ok_c = (STRICT_LEN != 0) ? (cnt == CNT_FULL) : (cnt >= CNT_FULL);
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            shadow    <= '0;
            cnt       <= '0;
            prog_en_q <= 1'b0;
            active    <= '0;
            cfg_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            prog_en_q <= prog_en;
            if (commit_c) begin
                cnt <= '0;
                if (len_ok_c) begin
                    active    <= shadow;
                    cfg_valid <= 1'b1;
                    cfg_err   <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else if (prog_en) begin
                shadow <= {prog_in, shadow[CFG_BITS-1:1]};
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign prog_out = shadow[0];

endmodule

// File: rtl/sb_cfg_switch_box.sv
// Parametrised switch box: each output track picks a same-index track from another side.
module sb_cfg_switch_box
    import sb_cfg_switch_box_pkg::*;
#(
    parameter int unsigned NSIDES     = 4,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned STRICT_LEN = 1,
    parameter int unsigned REG_OUT    = 0
) (
    input  logic                    prog_clk,
    input  logic                    prog_rst_n,
    input  logic                    prog_in,
    input  logic                    prog_en,
    output logic                    prog_out,
    input  logic [NSIDES*WIDTH-1:0] in_bus,
    output logic [NSIDES*WIDTH-1:0] out_bus,
    output logic                    cfg_valid,
    output logic                    cfg_err
);

    localparam int unsigned SEL_W    = sel_w(NSIDES);
    localparam int unsigned CFG_BITS = cfg_bits(NSIDES, WIDTH);
    localparam int unsigned NSEL     = 1 << SEL_W;
    localparam int unsigned BUS_W    = NSIDES * WIDTH;

    logic [CFG_BITS-1:0] active;
    logic [BUS_W-1:0]    route_c;

    sb_cfg_chain #(
        .CFG_BITS   (CFG_BITS),
        .STRICT_LEN (STRICT_LEN)
    ) u_chain (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .prog_in    (prog_in),
        .prog_en    (prog_en),
        .prog_out   (prog_out),
        .active     (active),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err)
    );

    // Per-track mux: candidate k is side (s+k) mod NSIDES; off and out-of-range codes give 0.
    for (genvar s = 0; s < NSIDES; s++) begin : g_side
        for (genvar t = 0; t < WIDTH; t++) begin : g_trk
            localparam int unsigned IDX = s * WIDTH + t;
            logic [SEL_W-1:0] sel;
            logic [NSEL-1:0]  cand;

            assign sel = active[IDX*SEL_W +: SEL_W];

            for (genvar k = 0; k < NSEL; k++) begin : g_cand
                if (k == SEL_OFF) begin : g_off
                    assign cand[k] = 1'b0;
                end else if (k >= SEL_REL1 && k < NSIDES) begin : g_rel
                    assign cand[k] = in_bus[((s + k) % NSIDES) * WIDTH + t];
                end else begin : g_bad
                    assign cand[k] = 1'b0;
                end
            end

            assign route_c[IDX] = cfg_valid & cand[sel];
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [BUS_W-1:0] out_q;
        always_ff @(posedge prog_clk or negedge prog_rst_n) begin
            if (!prog_rst_n) begin
                out_q <= '0;
            end else begin
                out_q <= route_c;
            end
        end
        assign out_bus = out_q;
    end else begin : g_comb
        assign out_bus = route_c;
    end

endmodule

// File: tb/tb_sb_cfg_switch_box.sv
// Self-checking bench: strict/registered pair plus a non-strict daisy chain against a bit-history model.
module tb_sb_cfg_switch_box;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_s, en_s, in_n, en_n;
    logic [15:0] in_bus;

    logic        po_a, po_r, po_n0, po_n1;
    logic [15:0] out_a, out_r, out_n0, out_n1;
    logic        v_a, e_a, v_r, e_r, v_n0, e_n0, v_n1, e_n1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          hist_s[$];
    bit          hist_n[$];
    int          cnt_s, cnt_n;
    logic [31:0] act_s, act_n0, act_n1;
    bit          val_s, err_s, val_n, err_n, enq_s, enq_n;
    logic [15:0] exp_r;

    always #5 clk = ~clk;

    sb_cfg_switch_box #(.NSIDES(4), .WIDTH(4), .STRICT_LEN(1), .REG_OUT(0)) u_a (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(in_s), .prog_en(en_s), .prog_out(po_a),
        .in_bus(in_bus), .out_bus(out_a), .cfg_valid(v_a), .cfg_err(e_a));
    sb_cfg_switch_box #(.NSIDES(4), .WIDTH(4), .STRICT_LEN(1), .REG_OUT(1)) u_r (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(in_s), .prog_en(en_s), .prog_out(po_r),
        .in_bus(in_bus), .out_bus(out_r), .cfg_valid(v_r), .cfg_err(e_r));
    sb_cfg_switch_box #(.NSIDES(4), .WIDTH(4), .STRICT_LEN(0), .REG_OUT(0)) u_n0 (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(in_n), .prog_en(en_n), .prog_out(po_n0),
        .in_bus(in_bus), .out_bus(out_n0), .cfg_valid(v_n0), .cfg_err(e_n0));
    sb_cfg_switch_box #(.NSIDES(4), .WIDTH(4), .STRICT_LEN(0), .REG_OUT(0)) u_n1 (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(po_n0), .prog_en(en_n), .prog_out(po_n1),
        .in_bus(in_bus), .out_bus(out_n1), .cfg_valid(v_n1), .cfg_err(e_n1));

    // Output side s, track t takes side (s+sel) mod 4 track t; sel 0 or invalid config gives 0.
    function automatic logic [15:0] route(input logic [15:0] ib, input logic [31:0] act, input bit v);
        logic [15:0] r;
        r = '0;
        if (v) begin
            for (int s = 0; s < 4; s++) begin
                for (int t = 0; t < 4; t++) begin
                    int sel;
                    sel = int'((act >> ((s * 4 + t) * 2)) & 32'd3);
                    if (sel != 0) r[s*4+t] = ib[((s + sel) % 4) * 4 + t];
                end
            end
        end
        return r;
    endfunction

    // The last 32 bits shifted (older bits first) form the shadow; never-written positions are 0.
    function automatic logic [31:0] shadow_s();
        logic [31:0] w;
        int n;
        w = '0;
        n = hist_s.size();
        for (int i = 0; i < 32; i++) begin
            if (n - 32 + i >= 0) w[i] = hist_s[n-32+i];
        end
        return w;
    endfunction

    function automatic logic [31:0] shadow_n(input int off);
        logic [31:0] w;
        int n;
        w = '0;
        n = hist_n.size();
        for (int i = 0; i < 32; i++) begin
            if (n - off - 32 + i >= 0) w[i] = hist_n[n-off-32+i];
        end
        return w;
    endfunction

    task automatic model_clear();
        hist_s.delete();
        hist_n.delete();
        cnt_s = 0; cnt_n = 0;
        act_s = '0; act_n0 = '0; act_n1 = '0;
        val_s = 0; err_s = 0; val_n = 0; err_n = 0;
        enq_s = 0; enq_n = 0;
        exp_r = '0;
    endtask

    // One clock edge; model advances from the inputs held across the edge.
    task automatic tick();
        logic [15:0] pre_r;
        pre_r = route(in_bus, act_s, val_s);
        @(posedge clk);
        #1;
        exp_r = pre_r;
        if (enq_s && !en_s) begin
            if (cnt_s == 32) begin
                act_s = shadow_s(); val_s = 1; err_s = 0;
            end else begin
                err_s = 1;
            end
            cnt_s = 0;
        end else if (en_s) begin
            hist_s.push_back(in_s);
            cnt_s++;
        end
        enq_s = en_s;
        if (enq_n && !en_n) begin
            if (cnt_n >= 32) begin
                act_n0 = shadow_n(0); act_n1 = shadow_n(32); val_n = 1; err_n = 0;
            end else begin
                err_n = 1;
            end
            cnt_n = 0;
        end else if (en_n) begin
            hist_n.push_back(in_n);
            cnt_n++;
        end
        enq_n = en_n;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        en_s = 0; en_n = 0; in_s = 0; in_n = 0;
        model_clear();
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_s(input logic [31:0] w, input int nbits);
        en_s = 1;
        for (int i = 0; i < nbits; i++) begin
            in_s = (i < 32) ? w[i] : 1'($urandom);
            tick();
        end
        en_s = 0;
        tick();
    endtask

    task automatic load_n(input logic [63:0] w, input int nbits);
        en_n = 1;
        for (int i = 0; i < nbits; i++) begin
            in_n = w[i];
            tick();
        end
        en_n = 0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_s = 0; en_n = 0; in_s = 0; in_n = 0;
        in_bus = 16'($urandom);
        model_clear();
        #3;
        tests++;
        if ({out_a, out_r, out_n0, out_n1} !== 64'h0) begin
            fails++;
            $display("FAIL reset_out got %h %h %h %h want 0", out_a, out_r, out_n0, out_n1);
        end
        tests++;
        if ({po_a, po_r, po_n0, po_n1, v_a, v_r, v_n0, v_n1, e_a, e_r, e_n0, e_n1} !== 12'h0) begin
            fails++;
            $display("FAIL reset_flags got po=%b%b%b%b v=%b%b%b%b e=%b%b%b%b want all 0",
                     po_a, po_r, po_n0, po_n1, v_a, v_r, v_n0, v_n1, e_a, e_r, e_n0, e_n1);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_load();
        in_bus = 16'h3914;
        load_s(32'h5555_5555, 32);
        tests++;
        if (v_a !== 1'b1 || e_a !== 1'b0) begin
            fails++;
            $display("FAIL basic_flags got v=%b e=%b want v=1 e=0", v_a, e_a);
        end
        tests++;
        if (out_a !== 16'h4391) begin
            fails++;
            $display("FAIL basic_out got %h want 4391", out_a);
        end
        tests++;
        if (out_r !== 16'h0000) begin
            fails++;
            $display("FAIL basic_reg_lag got %h want 0000", out_r);
        end
        tick();
        tests++;
        if (out_r !== 16'h4391) begin
            fails++;
            $display("FAIL basic_reg_out got %h want 4391", out_r);
        end
    endtask

    task automatic test_reload_latency();
        in_bus = 16'h3914;
        load_s(32'hAAAA_AAAA, 32);
        tests++;
        if (out_a !== 16'h1439 || out_r !== 16'h4391) begin
            fails++;
            $display("FAIL reload_commit got a=%h r=%h want a=1439 r=4391", out_a, out_r);
        end
        tick();
        tests++;
        if (out_r !== 16'h1439) begin
            fails++;
            $display("FAIL reload_reg got %h want 1439", out_r);
        end
        for (int i = 0; i < 8; i++) begin
            in_bus = 16'($urandom);
            #1;
            tests++;
            if (out_a !== route(in_bus, act_s, val_s)) begin
                fails++;
                $display("FAIL reload_comb_data got %h want %h", out_a, route(in_bus, act_s, val_s));
            end
            tick();
            tests++;
            if (out_r !== exp_r) begin
                fails++;
                $display("FAIL reload_reg_data got %h want %h", out_r, exp_r);
            end
        end
        in_bus = 16'h3914;
    endtask

    task automatic test_strict_len();
        int lens[3] = '{31, 33, 32};
        logic [31:0] w;
        in_bus = 16'h3914;
        for (int i = 0; i < 3; i++) begin
            w = (lens[i] == 32) ? 32'h5555_5555 : $urandom;
            load_s(w, lens[i]);
            tests++;
            if (e_a !== ((lens[i] == 32) ? 1'b0 : 1'b1) || v_a !== 1'b1) begin
                fails++;
                $display("FAIL strict_len%0d got e=%b v=%b want e=%b v=1", lens[i], e_a, v_a,
                         (lens[i] == 32) ? 1'b0 : 1'b1);
            end
            tests++;
            if (out_a !== ((lens[i] == 32) ? 16'h4391 : 16'h1439)) begin
                fails++;
                $display("FAIL strict_out%0d got %h want %h", lens[i], out_a,
                         (lens[i] == 32) ? 16'h4391 : 16'h1439);
            end
        end
    endtask

    task automatic test_nonstrict();
        in_bus = 16'h3914;
        load_n(64'h0000_0000_AAAA_AAAA, 33);
        tests++;
        if (v_n0 !== 1'b1 || e_n0 !== 1'b0) begin
            fails++;
            $display("FAIL nonstrict_flags got v=%b e=%b want v=1 e=0", v_n0, e_n0);
        end
        tests++;
        if (out_n0 !== 16'h4391) begin
            fails++;
            $display("FAIL nonstrict_out got %h want 4391", out_n0);
        end
        tests++;
        if (out_n1 !== route(in_bus, act_n1, val_n) || v_n1 !== val_n) begin
            fails++;
            $display("FAIL nonstrict_tail got %h v=%b want %h v=%b", out_n1, v_n1,
                     route(in_bus, act_n1, val_n), val_n);
        end
    endtask

    task automatic test_daisy();
        logic [31:0] wa;
        bit exp_po[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        in_bus = 16'h3914;
        wa = $urandom;
        en_n = 1;
        for (int i = 0; i < 64; i++) begin
            in_n = (i < 32) ? ((i % 2) == 0) : wa[i-32];
            tick();
            if (i >= 31 && i <= 34) begin
                tests++;
                if (po_n0 !== exp_po[i-31]) begin
                    fails++;
                    $display("FAIL daisy_po_shift%0d got %b want %b", i + 1, po_n0, exp_po[i-31]);
                end
            end
        end
        en_n = 0;
        tick();
        tests++;
        if (out_n1 !== 16'h4391 || v_n1 !== 1'b1) begin
            fails++;
            $display("FAIL daisy_tail got %h v=%b want 4391 v=1", out_n1, v_n1);
        end
        for (int i = 0; i < 6; i++) begin
            in_bus = 16'($urandom);
            #1;
            tests++;
            if (out_n0 !== route(in_bus, wa, 1'b1) || out_n1 !== route(in_bus, act_n1, val_n)) begin
                fails++;
                $display("FAIL daisy_route got a=%h b=%h want a=%h b=%h", out_n0, out_n1,
                         route(in_bus, wa, 1'b1), route(in_bus, act_n1, val_n));
            end
            tick();
        end
    endtask

    task automatic test_midload_reset();
        logic [31:0] w;
        in_bus = 16'hFFFF;
        en_s = 1;
        for (int i = 0; i < 16; i++) begin
            in_s = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        en_s = 0;
        model_clear();
        #2;
        tests++;
        if (out_a !== 16'h0 || out_r !== 16'h0 || v_a !== 1'b0 || po_a !== 1'b0) begin
            fails++;
            $display("FAIL midreset got out=%h r=%h v=%b po=%b want 0", out_a, out_r, v_a, po_a);
        end
        rst_n = 1'b1;
        tick();
        w = $urandom;
        w[1:0] = 2'b00;
        load_s(w, 32);
        for (int i = 0; i < 6; i++) begin
            in_bus = 16'($urandom);
            #1;
            tests++;
            if (out_a !== route(in_bus, w, 1'b1) || out_a[0] !== 1'b0) begin
                fails++;
                $display("FAIL postreset_route got %h want %h", out_a, route(in_bus, w, 1'b1));
            end
            tick();
        end
        load_s(32'h0, 32);
        in_bus = 16'hFFFF;
        #1;
        tests++;
        if (out_a !== 16'h0 || v_a !== 1'b1) begin
            fails++;
            $display("FAIL zero_cfg got %h v=%b want 0000 v=1", out_a, v_a);
        end
    endtask

    task automatic test_random();
        logic [31:0] sh;
        for (int it = 0; it < 20; it++) begin
            load_s($urandom, $urandom_range(30, 34));
            tests++;
            if (e_a !== err_s || v_a !== val_s || e_r !== err_s) begin
                fails++;
                $display("FAIL rand_flags it%0d got e=%b v=%b want e=%b v=%b", it, e_a, v_a, err_s, val_s);
            end
            sh = shadow_s();
            tests++;
            if (po_a !== sh[0]) begin
                fails++;
                $display("FAIL rand_prog_out it%0d got %b want %b", it, po_a, sh[0]);
            end
            in_bus = 16'($urandom);
            #1;
            tests++;
            if (out_a !== route(in_bus, act_s, val_s)) begin
                fails++;
                $display("FAIL rand_route it%0d got %h want %h", it, out_a, route(in_bus, act_s, val_s));
            end
            tick();
            tests++;
            if (out_r !== exp_r) begin
                fails++;
                $display("FAIL rand_reg it%0d got %h want %h", it, out_r, exp_r);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_reload_latency();
        test_strict_len();
        test_nonstrict();
        test_daisy();
        test_midload_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
